// File: rtl/q_agent_driver_pkg.sv
// Shared widths, action encodings and FSM state type for the Q-learning agent driver.
package q_agent_driver_pkg;

    localparam int STATES_WIDTH  = 4;
    localparam int ACTIONS_WIDTH = 2;
    localparam int DATA_WIDTH    = 16;
    localparam int ACTIONS       = 4;

    localparam logic [ACTIONS_WIDTH-1:0] ACT_UP    = 2'd0;
    localparam logic [ACTIONS_WIDTH-1:0] ACT_DOWN  = 2'd1;
    localparam logic [ACTIONS_WIDTH-1:0] ACT_LEFT  = 2'd2;
    localparam logic [ACTIONS_WIDTH-1:0] ACT_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_WAIT,
        S_EPI_END,
        S_DONE
    } agent_state_t;

endpackage

// File: rtl/q_agent_driver_grid_env_step.sv
// Combinational grid-world environment: (state, action) -> (next state, reward).
module grid_env_step
    import q_agent_driver_pkg::*;
#(
    parameter int GRID_COLS   = 4,
    parameter int GRID_ROWS   = 4,
    parameter int GOAL_STATE  = 15,
    parameter int REWARD_GOAL = 256,
    parameter int REWARD_WALL = -256,
    parameter int REWARD_STEP = -16
) (
    input  logic [STATES_WIDTH-1:0]  st_i,
    input  logic [ACTIONS_WIDTH-1:0] at_i,
    output logic [STATES_WIDTH-1:0]  next_st_o,
    output logic [DATA_WIDTH-1:0]    rt_o
);

    localparam logic [STATES_WIDTH-1:0] COLS     = STATES_WIDTH'(GRID_COLS);
    localparam logic [STATES_WIDTH-1:0] LAST_COL = STATES_WIDTH'(GRID_COLS - 1);
    localparam logic [STATES_WIDTH-1:0] LAST_ROW = STATES_WIDTH'(GRID_ROWS - 1);
    localparam logic [STATES_WIDTH-1:0] GOAL     = STATES_WIDTH'(GOAL_STATE);

    logic [STATES_WIDTH-1:0] row;
    logic [STATES_WIDTH-1:0] col;
    logic                    wall;

    always_comb begin
        row       = st_i / COLS;
        col       = st_i % COLS;
        wall      = 1'b0;
        next_st_o = st_i;
        case (at_i)
            ACT_UP:    if (row == '0)       wall = 1'b1; else next_st_o = st_i - COLS;
            ACT_DOWN:  if (row == LAST_ROW) wall = 1'b1; else next_st_o = st_i + COLS;
            ACT_LEFT:  if (col == '0)       wall = 1'b1; else next_st_o = st_i - 1'b1;
            ACT_RIGHT: if (col == LAST_COL) wall = 1'b1; else next_st_o = st_i + 1'b1;
        endcase

        if (wall)
            rt_o = DATA_WIDTH'(REWARD_WALL);
        else if (next_st_o == GOAL)
            rt_o = DATA_WIDTH'(REWARD_GOAL);
        else
            rt_o = DATA_WIDTH'(REWARD_STEP);
    end

endmodule

// File: rtl/q_agent_driver.sv
// Episode driver for the Q-learning datapath: epsilon-greedy grid walk, one transition per step.
// Define Q_AGENT_DUMP_EN to pulse o_write_file_en for one cycle on entry to DONE.
module q_agent_driver
    import q_agent_driver_pkg::*;
#(
    parameter int          GRID_COLS   = 4,
    parameter int          GRID_ROWS   = 4,
    parameter int          START_STATE = 0,
    parameter int          GOAL_STATE  = 15,
    parameter int          MAX_STEPS   = 64,
    parameter int          EPSILON     = 26,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          REWARD_GOAL = 256,
    parameter int          REWARD_WALL = -256,
    parameter int          REWARD_STEP = -16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic [15:0]              i_num_episodes,
    input  logic [ACTIONS_WIDTH-1:0] i_at_max,
    input  logic                     i_upd_valid,
    output logic                     o_valid,
    output logic [STATES_WIDTH-1:0]  o_st,
    output logic [STATES_WIDTH-1:0]  o_next_st,
    output logic [ACTIONS_WIDTH-1:0] o_at,
    output logic [DATA_WIDTH-1:0]    o_rt,
    output logic                     o_write_file_en,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [15:0]              o_episode_cnt,
    output logic [15:0]              o_step_cnt
);

`ifdef Q_AGENT_DUMP_EN
    localparam logic DUMP_EN = 1'b1;
`else
    localparam logic DUMP_EN = 1'b0;
`endif

    localparam logic [STATES_WIDTH-1:0] START = STATES_WIDTH'(START_STATE);
    localparam logic [STATES_WIDTH-1:0] GOAL  = STATES_WIDTH'(GOAL_STATE);

    agent_state_t             state_q;
    logic [15:0]              lfsr_q;
    logic [15:0]              lfsr_d;
    logic [ACTIONS_WIDTH-1:0] g_at_q;
    logic [ACTIONS_WIDTH-1:0] at_d;
    logic [STATES_WIDTH-1:0]  st_q;
    logic [STATES_WIDTH-1:0]  env_next_st;
    logic [DATA_WIDTH-1:0]    env_rt;
    logic [15:0]              num_eps_q;
    logic [15:0]              episode_cnt_q;
    logic [15:0]              step_cnt_q;
    logic                     valid_q, busy_q, done_q, wfe_q;
    logic [STATES_WIDTH-1:0]  o_st_q, o_next_st_q;
    logic [ACTIONS_WIDTH-1:0] o_at_q;
    logic [DATA_WIDTH-1:0]    o_rt_q;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        at_d   = (lfsr_q[7:0] < 8'(EPSILON)) ? lfsr_q[9:8] : g_at_q;
    end

    grid_env_step #(
        .GRID_COLS  (GRID_COLS),
        .GRID_ROWS  (GRID_ROWS),
        .GOAL_STATE (GOAL_STATE),
        .REWARD_GOAL(REWARD_GOAL),
        .REWARD_WALL(REWARD_WALL),
        .REWARD_STEP(REWARD_STEP)
    ) u_env (
        .st_i     (st_q),
        .at_i     (at_d),
        .next_st_o(env_next_st),
        .rt_o     (env_rt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            lfsr_q        <= LFSR_SEED;
            g_at_q        <= '0;
            st_q          <= '0;
            num_eps_q     <= '0;
            episode_cnt_q <= '0;
            step_cnt_q    <= '0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            wfe_q         <= 1'b0;
            o_st_q        <= '0;
            o_next_st_q   <= '0;
            o_at_q        <= '0;
            o_rt_q        <= '0;
        end else begin
            valid_q <= 1'b0;
            wfe_q   <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        num_eps_q     <= i_num_episodes;
                        st_q          <= START;
                        episode_cnt_q <= '0;
                        step_cnt_q    <= '0;
                        g_at_q        <= '0;
                        if (i_num_episodes == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            wfe_q   <= DUMP_EN;
                        end else begin
                            state_q <= S_SELECT;
                            done_q  <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_SELECT: begin
                    lfsr_q      <= lfsr_d;
                    o_st_q      <= st_q;
                    o_next_st_q <= env_next_st;
                    o_at_q      <= at_d;
                    o_rt_q      <= env_rt;
                    valid_q     <= 1'b1;
                    state_q     <= S_ISSUE;
                end
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT: begin
                    if (i_upd_valid) begin
                        step_cnt_q <= step_cnt_q + 16'd1;
                        g_at_q     <= i_at_max;
                        if (o_next_st_q == GOAL || step_cnt_q + 16'd1 == 16'(MAX_STEPS)) begin
                            state_q <= S_EPI_END;
                        end else begin
                            st_q    <= o_next_st_q;
                            state_q <= S_SELECT;
                        end
                    end
                end
                S_EPI_END: begin
                    episode_cnt_q <= episode_cnt_q + 16'd1;
                    st_q          <= START;
                    step_cnt_q    <= '0;
                    g_at_q        <= '0;
                    if (episode_cnt_q + 16'd1 == num_eps_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        wfe_q   <= DUMP_EN;
                    end else begin
                        state_q <= S_SELECT;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_valid         = valid_q;
    assign o_st            = o_st_q;
    assign o_next_st       = o_next_st_q;
    assign o_at            = o_at_q;
    assign o_rt            = o_rt_q;
    assign o_write_file_en = wfe_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_episode_cnt   = episode_cnt_q;
    assign o_step_cnt      = step_cnt_q;

endmodule

// File: tb/tb_q_agent_driver.sv
// Directed bench for q_agent_driver: three instances (greedy walk, short episodes, full explore).
module tb_q_agent_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start [3];
    logic [15:0] neps  [3];
    logic [1:0]  atm   [3];
    logic        upd   [3];
    logic        ov    [3];
    logic [3:0]  ost   [3];
    logic [3:0]  onst  [3];
    logic [1:0]  oat   [3];
    logic [15:0] ort   [3];
    logic        owf   [3];
    logic        obusy [3];
    logic        odone [3];
    logic [15:0] oep   [3];
    logic [15:0] ostep [3];

    int tests = 0;
    int fails = 0;
    int wf_pulses = 0;
    int wf_misalign = 0;
    logic done_prev = 1'b0;

    always #5 clk = ~clk;

    q_agent_driver #(.EPSILON(0)) u_a (
        .clk(clk), .rst_n(rst_n), .i_start(start[0]), .i_num_episodes(neps[0]),
        .i_at_max(atm[0]), .i_upd_valid(upd[0]), .o_valid(ov[0]), .o_st(ost[0]),
        .o_next_st(onst[0]), .o_at(oat[0]), .o_rt(ort[0]), .o_write_file_en(owf[0]),
        .o_busy(obusy[0]), .o_done(odone[0]), .o_episode_cnt(oep[0]), .o_step_cnt(ostep[0]));

    q_agent_driver #(.EPSILON(0), .MAX_STEPS(4)) u_b (
        .clk(clk), .rst_n(rst_n), .i_start(start[1]), .i_num_episodes(neps[1]),
        .i_at_max(atm[1]), .i_upd_valid(upd[1]), .o_valid(ov[1]), .o_st(ost[1]),
        .o_next_st(onst[1]), .o_at(oat[1]), .o_rt(ort[1]), .o_write_file_en(owf[1]),
        .o_busy(obusy[1]), .o_done(odone[1]), .o_episode_cnt(oep[1]), .o_step_cnt(ostep[1]));

    q_agent_driver #(.EPSILON(255), .MAX_STEPS(3), .LFSR_SEED(16'hACE1)) u_c (
        .clk(clk), .rst_n(rst_n), .i_start(start[2]), .i_num_episodes(neps[2]),
        .i_at_max(atm[2]), .i_upd_valid(upd[2]), .o_valid(ov[2]), .o_st(ost[2]),
        .o_next_st(onst[2]), .o_at(oat[2]), .o_rt(ort[2]), .o_write_file_en(owf[2]),
        .o_busy(obusy[2]), .o_done(odone[2]), .o_episode_cnt(oep[2]), .o_step_cnt(ostep[2]));

    // Dump-strobe observer for instance B.
    always @(negedge clk) begin
        if (owf[1] === 1'b1) begin
            wf_pulses++;
            if (!(odone[1] === 1'b1 && done_prev === 1'b0)) wf_misalign++;
        end
        done_prev = odone[1];
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int k, input string tag);
        int c;
        c = 0;
        while (ov[k] !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        chk(tag, 32'(ov[k]), 32'd1);
    endtask

    task automatic respond(input int k, input logic [1:0] a);
        tick();
        chk("valid_one_cycle", 32'(ov[k]), 32'd0);
        upd[k] = 1'b1;
        atm[k] = a;
        tick();
        upd[k] = 1'b0;
    endtask

    initial begin : stim
        logic [3:0]  st_e  [7] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd11};
        logic [3:0]  nst_e [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd11, 4'd15};
        logic [1:0]  at_e  [7] = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd1, 2'd1, 2'd1};
        logic [15:0] rt_e  [7] = '{16'hFF00, 16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0, 16'h0100};
        logic [1:0]  resp  [7] = '{2'd3, 2'd3, 2'd3, 2'd1, 2'd1, 2'd1, 2'd0};
        logic [15:0] lfsr_m;
        logic [1:0]  g_m;
        logic [1:0]  exp_at;
        int          exp_dump;

        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0; neps[k] = '0; atm[k] = '0; upd[k] = 1'b0;
        end
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_valid", 32'(ov[0]), 32'd0);
        chk("rst_busy_done", {30'd0, obusy[0], odone[0]}, 32'd0);
        chk("rst_st_nst_at", {22'd0, ost[0], onst[0], oat[0]}, 32'd0);
        chk("rst_rt", 32'(ort[0]), 32'd0);
        chk("rst_counts", {oep[0], ostep[0]}, 32'd0);
        chk("rst_wfe", 32'(owf[0]), 32'd0);

        // Greedy walk to the goal on instance A
        start[0] = 1'b1; neps[0] = 16'd1;
        tick();
        start[0] = 1'b0;
        chk("start_busy", 32'(obusy[0]), 32'd1);
        chk("start_sel_no_valid", 32'(ov[0]), 32'd0);
        tick();
        chk("start_to_valid", 32'(ov[0]), 32'd1);
        for (int i = 0; i < 7; i++) begin
            wait_valid(0, "a_wait_valid");
            chk("a_st", 32'(ost[0]), 32'(st_e[i]));
            chk("a_next_st", 32'(onst[0]), 32'(nst_e[i]));
            chk("a_at", 32'(oat[0]), 32'(at_e[i]));
            chk("a_rt", 32'(ort[0]), 32'(rt_e[i]));
            respond(0, resp[i]);
            chk("a_step_cnt", 32'(ostep[0]), 32'(i + 1));
            chk("a_after_upd_no_valid", 32'(ov[0]), 32'd0);
            tick();
            if (i < 6) chk("upd_to_valid", 32'(ov[0]), 32'd1);
        end
        chk("a_done", 32'(odone[0]), 32'd1);
        chk("a_busy_clear", 32'(obusy[0]), 32'd0);
        chk("a_episode_cnt", 32'(oep[0]), 32'd1);
        chk("a_step_cnt_clear", 32'(ostep[0]), 32'd0);

        // Step limit, two episodes on instance B
        start[1] = 1'b1; neps[1] = 16'd2;
        tick();
        start[1] = 1'b0;
        for (int e = 0; e < 2; e++) begin
            for (int s = 0; s < 4; s++) begin
                wait_valid(1, "b_wait_valid");
                chk("b_transition", {14'd0, ost[1], onst[1], oat[1], ort[1]}, {14'd0, 4'd0, 4'd0, 2'd0, 16'hFF00});
                respond(1, 2'd0);
            end
            chk("b_step_at_limit", 32'(ostep[1]), 32'd4);
            tick();
            chk("b_step_reset", 32'(ostep[1]), 32'd0);
            chk("b_episode_cnt", 32'(oep[1]), 32'(e + 1));
            if (e == 0) begin
                chk("b_boundary_no_valid", 32'(ov[1]), 32'd0);
                tick();
                chk("b_epi_boundary_valid", 32'(ov[1]), 32'd1);
            end else begin
                chk("b_done", 32'(odone[1]), 32'd1);
            end
        end
        tick();

        // Zero episodes on instance C
        start[2] = 1'b1; neps[2] = 16'd0;
        tick();
        start[2] = 1'b0;
        chk("c_zero_done", 32'(odone[2]), 32'd1);
        chk("c_zero_busy", 32'(obusy[2]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("c_zero_no_valid", 32'(ov[2]), 32'd0);
        end

        // Full exploration on instance C, with an ignored start while busy
        lfsr_m = 16'hACE1;
        g_m    = 2'd0;
        start[2] = 1'b1; neps[2] = 16'd1;
        tick();
        start[2] = 1'b0;
        chk("c_done_cleared", 32'(odone[2]), 32'd0);
        for (int s = 0; s < 3; s++) begin
            wait_valid(2, "c_wait_valid");
            exp_at = (lfsr_m[7:0] < 8'd255) ? lfsr_m[9:8] : g_m;
            chk("c_explore_at", 32'(oat[2]), 32'(exp_at));
            lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
            if (s == 0) begin
                start[2] = 1'b1; neps[2] = 16'd7;
                tick();
                start[2] = 1'b0;
                chk("c_busy_start_busy", 32'(obusy[2]), 32'd1);
                chk("c_busy_start_step", 32'(ostep[2]), 32'd0);
                chk("c_busy_start_hold_at", 32'(oat[2]), 32'(exp_at));
                upd[2] = 1'b1; atm[2] = 2'd2;
                tick();
                upd[2] = 1'b0;
            end else begin
                respond(2, 2'd2);
            end
            g_m = 2'd2;
        end
        tick();
        chk("c_done", 32'(odone[2]), 32'd1);
        chk("c_episode_cnt", 32'(oep[2]), 32'd1);

`ifdef Q_AGENT_DUMP_EN
        exp_dump = 1;
`else
        exp_dump = 0;
`endif
        chk("dump_pulses", 32'(wf_pulses), 32'(exp_dump));
        chk("dump_alignment", 32'(wf_misalign), 32'd0);

        // Mid-operation reset on instance A
        start[0] = 1'b1; neps[0] = 16'd1;
        tick();
        start[0] = 1'b0;
        wait_valid(0, "r_wait_valid");
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_flags", {27'd0, ov[0], obusy[0], odone[0], owf[0], 1'b0}, 32'd0);
        chk("mid_rst_st_nst_at", {22'd0, ost[0], onst[0], oat[0]}, 32'd0);
        chk("mid_rst_rt", 32'(ort[0]), 32'd0);
        chk("mid_rst_counts", {oep[0], ostep[0]}, 32'd0);
        upd[0] = 1'b1; atm[0] = 2'd3;
        tick();
        upd[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("late_upd_no_valid", 32'(ov[0]), 32'd0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
